// File: rtl/dmem_mmio_responder.sv
// dmem_mmio_responder: word RAM plus MMIO window (output FIFO, LED register, cycle counter) behind the dmem port
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   address_dmem in   12-bit word address
//   data         in   32-bit write data
//   wren         in   write enable
//   q_dmem       out  registered read data, one clock latency, read-before-write
//   out_data     out  FIFO head word (0 when empty)
//   out_valid    out  FIFO non-empty
//   out_ready    in   consumer accepts head on out_valid & out_ready
//   led_out      out  LED register
module dmem_mmio_responder #(
    parameter int RAM_DEPTH  = 256,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] address_dmem,
    input  logic [31:0] data,
    input  logic        wren,
    output logic [31:0] q_dmem,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] led_out
);
    localparam int AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [11:0] A_FIFO = 12'hFF0;
    localparam logic [11:0] A_LED  = 12'hFF1;
    localparam logic [11:0] A_CYC  = 12'hFF2;
    localparam logic [11:0] A_CLR  = 12'hFF3;

    logic [31:0]   r_ram  [RAM_DEPTH];
    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [4:0]    r_count;
    logic          r_ovf;
    logic [31:0]   r_cycles;
    logic [31:0]   r_led;

    logic          w_in_ram;
    logic [AW-1:0] w_ram_addr;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic          w_push_ok;
    logic [31:0]   w_rdata;

    assign w_in_ram   = {20'd0, address_dmem} < 32'(RAM_DEPTH);
    assign w_ram_addr = address_dmem[AW-1:0];
    assign w_full     = r_count == 5'(FIFO_DEPTH);
    assign out_valid  = r_count != 5'd0;
    assign out_data   = out_valid ? r_fifo[r_rd_ptr] : 32'd0;
    assign led_out    = r_led;
    assign w_push     = wren & (address_dmem == A_FIFO);
    assign w_pop      = out_valid & out_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO still lands
    assign w_push_ok  = w_push & (~w_full | w_pop);

    assign w_rdata = w_in_ram                 ? r_ram[w_ram_addr] :
                     address_dmem == A_FIFO   ? {r_ovf, 26'd0, r_count} :
                     address_dmem == A_LED    ? r_led :
                     address_dmem == A_CYC    ? r_cycles :
                                                32'd0;

    // Storage arrays are not reset; FIFO contents are masked by the count
    always_ff @(posedge clock) begin
        if (wren && w_in_ram)
            r_ram[w_ram_addr] <= data;
        if (w_push_ok)
            r_fifo[r_wr_ptr] <= data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            q_dmem   <= 32'd0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= 5'd0;
            r_ovf    <= 1'b0;
            r_cycles <= 32'd0;
            r_led    <= 32'd0;
        end else begin
            q_dmem   <= w_rdata;
            r_cycles <= (wren && address_dmem == A_CYC) ? data : r_cycles + 32'd1;
            if (wren && address_dmem == A_LED)
                r_led <= data;
            if (wren && address_dmem == A_CLR)
                r_ovf <= 1'b0;
            else if (w_push && w_full && !w_pop)
                r_ovf <= 1'b1;
            if (w_push_ok)
                r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + PW'(1);
            r_count <= r_count + 5'(w_push_ok) - 5'(w_pop);
        end
    end
endmodule

// File: tb/tb_dmem_mmio_responder.sv
// tb_dmem_mmio_responder: directed and random checks of the dmem MMIO responder against a queue-based model
module tb_dmem_mmio_responder;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [11:0] address_dmem = 12'd0;
    logic [31:0] data = 32'd0;
    logic        wren = 1'b0;
    logic        out_ready = 1'b0;
    logic [31:0] q_dmem;
    logic [31:0] out_data;
    logic        out_valid;
    logic [31:0] led_out;

    always #5 clock = ~clock;

    dmem_mmio_responder #(.RAM_DEPTH(256), .FIFO_DEPTH(DEPTH)) dut (
        .clock(clock),
        .reset(reset),
        .address_dmem(address_dmem),
        .data(data),
        .wren(wren),
        .q_dmem(q_dmem),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .led_out(led_out)
    );

    int n_checks = 0;
    int n_fail = 0;

    bit [31:0] m_ram [256];
    bit        m_known [256];
    bit [31:0] m_q [$];
    bit        m_ovf;
    bit [31:0] m_led;
    bit [31:0] m_cyc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, predict from the rules, then compare after the edge
    task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
        bit [31:0] rd;
        bit        rd_known;
        bit        pop;
        bit        push;
        int        sz;
        address_dmem = a;
        data = d;
        wren = we;
        out_ready = rdy;
        sz = m_q.size();
        rd_known = 1'b1;
        if (a < 12'd256) begin
            rd = m_ram[a[7:0]];
            rd_known = m_known[a[7:0]];
        end else if (a == 12'hFF0) rd = {m_ovf, 26'd0, 5'(sz)};
        else if (a == 12'hFF1) rd = m_led;
        else if (a == 12'hFF2) rd = m_cyc;
        else rd = 32'd0;
        pop = (sz > 0) && rdy;
        push = we && (a == 12'hFF0);
        @(posedge clock);
        #1;
        if (pop) void'(m_q.pop_front());
        if (push) begin
            if (sz < DEPTH || pop) m_q.push_back(d);
            else m_ovf = 1'b1;
        end
        if (we && a == 12'hFF3) m_ovf = 1'b0;
        if (we && a == 12'hFF1) m_led = d;
        m_cyc = (we && a == 12'hFF2) ? d : m_cyc + 32'd1;
        if (we && a < 12'd256) begin
            m_ram[a[7:0]] = d;
            m_known[a[7:0]] = 1'b1;
        end
        if (rd_known) check("q_dmem", q_dmem, rd);
        check("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        check("out_data", out_data, (m_q.size() > 0) ? m_q[0] : 32'd0);
        check("led_out", led_out, m_led);
    endtask

    // Asserts reset between edges and checks outputs clear without a clock
    task automatic do_reset();
        reset = 1'b0;
        #1;
        m_q.delete();
        m_ovf = 1'b0;
        m_led = 32'd0;
        m_cyc = 32'd0;
        check("rst_q_dmem", q_dmem, 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_led_out", led_out, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        bit [11:0] a;
        bit [31:0] d;
        #3;
        do_reset();
        // RAM[0x010] write then read
        step(12'h010, 32'hDEADBEEF, 1'b1, 1'b0);
        step(12'h010, 32'd0, 1'b0, 1'b0);
        check("ram_read", q_dmem, 32'hDEADBEEF);
        step(12'h800, 32'd0, 1'b0, 1'b0);
        check("unmapped_read", q_dmem, 32'd0);
        // LED write/read
        step(12'hFF1, 32'h000000A5, 1'b1, 1'b0);
        check("led_after_write", led_out, 32'h000000A5);
        step(12'hFF1, 32'd0, 1'b0, 1'b0);
        check("led_read", q_dmem, 32'h000000A5);
        // Overflow: five pushes into a depth-4 FIFO
        for (int i = 1; i <= 5; i++) step(12'hFF0, 32'(i * 32'h11), 1'b1, 1'b0);
        check("fifo_head", out_data, 32'h00000011);
        step(12'hFF0, 32'd0, 1'b0, 1'b0);
        check("status_overflow", q_dmem, 32'h80000004);
        for (int i = 0; i < 5; i++) step(12'h800, 32'd0, 1'b0, 1'b1);
        check("drained_valid", 32'(out_valid), 32'd0);
        // Clear overflow
        step(12'hFF3, 32'd0, 1'b1, 1'b0);
        step(12'hFF0, 32'd0, 1'b0, 1'b0);
        check("status_cleared", q_dmem, 32'd0);
        // Push into full FIFO with simultaneous pop
        for (int i = 0; i < 4; i++) step(12'hFF0, 32'h70 + 32'(i), 1'b1, 1'b0);
        step(12'hFF0, 32'h66, 1'b1, 1'b1);
        step(12'hFF0, 32'd0, 1'b0, 1'b0);
        check("status_full_pop_push", q_dmem, 32'h00000004);
        for (int i = 0; i < 3; i++) step(12'h800, 32'd0, 1'b0, 1'b1);
        check("last_drain_0x66", out_data, 32'h66);
        step(12'h800, 32'd0, 1'b0, 1'b1);
        // Reset mid-operation with LED set and FIFO occupied
        step(12'hFF1, 32'h12345678, 1'b1, 1'b0);
        step(12'hFF0, 32'hAB, 1'b1, 1'b0);
        step(12'hFF0, 32'hCD, 1'b1, 1'b0);
        do_reset();
        // Cycle counter wrap
        step(12'hFF2, 32'hFFFFFFFE, 1'b1, 1'b0);
        step(12'h800, 32'd0, 1'b0, 1'b0);
        step(12'hFF2, 32'd0, 1'b0, 1'b0);
        check("cycles_max", q_dmem, 32'hFFFFFFFF);
        step(12'hFF2, 32'd0, 1'b0, 1'b0);
        check("cycles_wrap", q_dmem, 32'd0);
        // Read-before-write on RAM
        step(12'h005, 32'd1, 1'b1, 1'b0);
        step(12'h005, 32'd2, 1'b1, 1'b0);
        check("rbw_old", q_dmem, 32'd1);
        step(12'h005, 32'd0, 1'b0, 1'b0);
        check("rbw_new", q_dmem, 32'd2);
        // Randomized traffic against the model
        for (int i = 0; i < 256; i++) step(12'(i), $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: a = 12'($urandom_range(0, 255));
                4, 5:       a = 12'hFF0;
                6:          a = 12'hFF1;
                7:          a = 12'hFF2;
                8:          a = 12'hFF3;
                default:    a = 12'($urandom);
            endcase
            d = ($urandom_range(0, 3) == 0) ? 32'hFFFFFFF0 + 32'($urandom_range(0, 15)) : $urandom;
            step(a, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
